ram_ws_rs_tag_multiway: RTL and testbench
=========================================

Name: ram_ws_rs_tag_multiway

Overview:
- Next-generation tag store for the L1.5 instruction cache.
- Replaces the single-way tag RAM wrapper with an NB_WAYS set-associative tag array. The array has a registered read port, per-way write enables and a built-in tag compare.
- An internal flush FSM invalidates every set automatically after reset and on request. The refill/lookup controller no longer walks the array itself.

Parameters:
- NB_WAYS, 4, number of ways (1..8).
- data_width, 7, stored tag width per way, valid bit included. Bit data_width-1 is the valid bit; bits data_width-2:0 are the tag.
- addr_width, 6, set index width; the array holds 2**addr_width sets.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_i  in  1  access request.
- gnt_o  out  1  grant; an access happens only when req_i & gnt_o.
- write_i  in  1  1 = write, 0 = read/lookup.
- way_en_i  in  NB_WAYS  write way mask; ignored on reads.
- addr_i  in  addr_width  set index.
- wdata_i  in  data_width  tag + valid bit, written to every enabled way.
- cmp_tag_i  in  data_width-1  tag compared on a read.
- rdata_o  out  NB_WAYS*data_width  stored entries; way w sits at [w*data_width +: data_width].
- rvalid_o  out  1  rdata_o, hit_o, hit_way_o and parity_err_o are valid this cycle.
- hit_o  out  1  at least one way hits.
- hit_way_o  out  NB_WAYS  one-hot (or zero) hit vector.
- parity_err_o  out  NB_WAYS  per-way parity error.
- flush_req_i  in  1  single-cycle pulse requesting invalidation of all sets.
- flush_busy_o  out  1  flush in progress.

Behaviour:
- Reset (rst=1 at an edge):
  - rvalid_o=0, hit_o=0, hit_way_o=0, parity_err_o=0, rdata_o=0.
  - FSM goes to FLUSH with set counter=0; flush_busy_o=1 and gnt_o=0 from the cycle after reset.
  - Storage contents are not reset directly; they are cleared by the flush.
- FSM states:
  - IDLE:
    - gnt_o=1, flush_busy_o=0.
    - flush_req_i=1 → FLUSH, counter=0. gnt_o is combinationally 0 in that cycle (flush wins over a same-cycle req_i).
  - FLUSH:
    - gnt_o=0, flush_busy_o=1.
    - Each cycle, all ways of set[counter] are written to all-zero (parity bit per the optional feature); counter increments.
    - When counter = 2**addr_width-1 and that set has been written → IDLE. A flush therefore takes exactly 2**addr_width cycles.
    - flush_req_i during FLUSH is ignored; no restart.
    - rst during FLUSH restarts the flush from counter=0.
- Write (req_i & gnt_o & write_i):
  - Ways with way_en_i[w]=1 take wdata_i at addr_i on the edge; other ways are unchanged.
  - rvalid_o=0 the next cycle.
  - way_en_i=0 is a legal no-op.
- Read (req_i & gnt_o & ~write_i):
  - Latency 1. On the next cycle rvalid_o=1, rdata_o holds all ways of addr_i, and cmp_tag_i is registered alongside.
  - hit_way_o[w] = rvalid_o & valid_w & (tag_w == registered cmp_tag) & ~parity_err_o[w].
  - hit_o = |hit_way_o.
  - Multiple hits (a software error) are reported as-is; no priority encoding.
- Idle cycles:
  - rdata_o holds its last value; rvalid_o=0.
  - hit_o and hit_way_o are 0 whenever rvalid_o=0.
- Read-after-write to the same set in back-to-back cycles returns the new data. No bypass is needed because reads and writes are sequential.
- Address width: addr_i is used in full; there is no wrap-around other than at 2**addr_width.

Optional Feature:
- Macro TAG_PARITY_EN.
- Defined:
  - Each way stores one extra even-parity bit over its data_width bits, computed on write and on flush (all-zero entries therefore store parity 0).
  - On read, parity_err_o[w] = rvalid_o & (recomputed parity != stored parity).
  - A way with a parity error never hits.
- Undefined:
  - No extra bit is stored; parity_err_o is tied to 0.
  - Port list is identical in both builds.

Test Plan:
- Reset: hold rst for 2 cycles, release. flush_busy_o=1 and gnt_o=0 for exactly 64 cycles (addr_width=6), then a read of set 5 gives rdata_o=0, hit_o=0.
- Write/lookup: write wdata=7'h55 to way 2 (way_en=4'b0100), set 3. Read set 3 with cmp_tag=6'h15 → next cycle rvalid_o=1, hit_o=1, hit_way_o=4'b0100, rdata_o way2 = 7'h55, other ways 0.
- Miss and invalid: write 7'h15 (valid=0) to way 0, set 3. Read with cmp_tag=6'h15 → hit_way_o=4'b0100 only; way 0 does not hit.
- Flush collision: flush_req_i and a read req_i in the same cycle → gnt_o=0, no rvalid_o. After 64 cycles all sets read back 0; a second flush_req_i at flush cycle 10 does not extend the flush.
- Reset mid-flush: assert rst at flush cycle 30 → flush restarts, flush_busy_o stays high for a further 64 cycles.
- TAG_PARITY_EN: force-flip a stored bit of way 1, set 7 (via hierarchical deposit). Read → parity_err_o=4'b0010 and way 1 excluded from hit_way_o. Without the macro, parity_err_o=0.

Source files
------------

// File: rtl/ram_ws_rs_tag_multiway_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_ws_rs_tag_multiway_if
// Description : Access/flush bus of the multi-way instruction-cache tag store.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_ws_rs_tag_multiway_if #(
    parameter int NB_WAYS    = 4,
    parameter int DATA_WIDTH = 7,
    parameter int ADDR_WIDTH = 6
);
    logic                          req_i;
    logic                          gnt_o;
    logic                          write_i;
    logic [NB_WAYS-1:0]            way_en_i;
    logic [ADDR_WIDTH-1:0]         addr_i;
    logic [DATA_WIDTH-1:0]         wdata_i;
    logic [DATA_WIDTH-2:0]         cmp_tag_i;
    logic [NB_WAYS*DATA_WIDTH-1:0] rdata_o;
    logic                          rvalid_o;
    logic                          hit_o;
    logic [NB_WAYS-1:0]            hit_way_o;
    logic [NB_WAYS-1:0]            parity_err_o;
    logic                          flush_req_i;
    logic                          flush_busy_o;

    modport master (
        output req_i, write_i, way_en_i, addr_i, wdata_i, cmp_tag_i, flush_req_i,
        input  gnt_o, rdata_o, rvalid_o, hit_o, hit_way_o, parity_err_o, flush_busy_o
    );

    modport slave (
        input  req_i, write_i, way_en_i, addr_i, wdata_i, cmp_tag_i, flush_req_i,
        output gnt_o, rdata_o, rvalid_o, hit_o, hit_way_o, parity_err_o, flush_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ram_ws_rs_tag_multiway.sv
`default_nettype none
// ============================================================================
// Module      : ram_ws_rs_tag_multiway
// Description : NB_WAYS set-associative tag array with registered read port,
//               built-in tag compare and self-running flush FSM.
//               Optional per-way even parity: define TAG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_ws_rs_tag_multiway #(
    parameter int NB_WAYS    = 4,
    parameter int DATA_WIDTH = 7,
    parameter int ADDR_WIDTH = 6
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ram_ws_rs_tag_multiway_if.slave    bus
);

    localparam int c_depth = 2**ADDR_WIDTH;
`ifdef TAG_PARITY_EN
    localparam int c_store_w = DATA_WIDTH + 1;
`else
    localparam int c_store_w = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] c_last_set = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_flush_cnt;
    logic [ADDR_WIDTH-1:0]   w_flush_cnt_nxt;
    logic                    w_gnt;
    logic                    w_busy;

    logic                    w_access;
    logic                    w_wr;
    logic                    w_rd;

    logic [NB_WAYS-1:0]      w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [c_store_w-1:0]    w_mem_wdata;

    logic [c_store_w-1:0]    r_mem    [0:c_depth-1][0:NB_WAYS-1];
    logic [c_store_w-1:0]    r_rd_ent [0:NB_WAYS-1];
    logic [DATA_WIDTH-2:0]   r_cmp_tag;
    logic                    r_rvalid;

    logic [NB_WAYS*DATA_WIDTH-1:0] w_rdata;
    logic [NB_WAYS-1:0]            w_hit_way;
    logic [NB_WAYS-1:0]            w_perr;

    // ------------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_gnt           = 1'b0;
        w_busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A same-cycle flush request takes priority over any access.
                w_gnt = ~bus.flush_req_i;
                if (bus.flush_req_i) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = '0;
                end
            end
            ST_FLUSH: begin
                w_busy          = 1'b1;
                w_flush_cnt_nxt = r_flush_cnt + 1'b1;
                if (r_flush_cnt == c_last_set) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_FLUSH;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    assign w_access = bus.req_i & w_gnt & ~rst;
    assign w_wr     = w_access &  bus.write_i;
    assign w_rd     = w_access & ~bus.write_i;

    // ------------------------------------------------------------------------
    // Storage write port: flush sweep or host write
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_we    = '0;
        w_mem_addr  = bus.addr_i;
        w_mem_wdata = '0;
        if (r_state == ST_FLUSH) begin
            // All-zero entry; its even parity bit is zero as well.
            w_mem_we    = '1;
            w_mem_addr  = r_flush_cnt;
            w_mem_wdata = '0;
        end else begin
            if (w_wr) begin
                w_mem_we = bus.way_en_i;
            end
`ifdef TAG_PARITY_EN
            w_mem_wdata = {^bus.wdata_i, bus.wdata_i};
`else
            w_mem_wdata = bus.wdata_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NB_WAYS; w++) begin
            if (w_mem_we[w]) begin
                r_mem[w_mem_addr][w] <= w_mem_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid  <= 1'b0;
            r_cmp_tag <= '0;
            for (int w = 0; w < NB_WAYS; w++) begin
                r_rd_ent[w] <= '0;
            end
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_cmp_tag <= bus.cmp_tag_i;
                for (int w = 0; w < NB_WAYS; w++) begin
                    r_rd_ent[w] <= r_mem[bus.addr_i][w];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag compare and parity check on the registered entries
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata   = '0;
        w_hit_way = '0;
        w_perr    = '0;
        for (int w = 0; w < NB_WAYS; w++) begin
            w_rdata[w*DATA_WIDTH +: DATA_WIDTH] = r_rd_ent[w][DATA_WIDTH-1:0];
`ifdef TAG_PARITY_EN
            // Stored word includes its parity bit, so a clean entry XORs to 0.
            w_perr[w] = r_rvalid & (^r_rd_ent[w]);
`endif
            w_hit_way[w] = r_rvalid
                         & r_rd_ent[w][DATA_WIDTH-1]
                         & (r_rd_ent[w][DATA_WIDTH-2:0] == r_cmp_tag)
                         & ~w_perr[w];
        end
    end

    assign bus.gnt_o        = w_gnt;
    assign bus.flush_busy_o = w_busy;
    assign bus.rvalid_o     = r_rvalid;
    assign bus.rdata_o      = w_rdata;
    assign bus.hit_way_o    = w_hit_way;
    assign bus.hit_o        = |w_hit_way;
    assign bus.parity_err_o = w_perr;

endmodule
`default_nettype wire

// File: tb/tb_ram_ws_rs_tag_multiway.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_ws_rs_tag_multiway
// Description : Directed self-checking bench for ram_ws_rs_tag_multiway.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_ws_rs_tag_multiway;

    localparam int NB_WAYS    = 4;
    localparam int DATA_WIDTH = 7;
    localparam int ADDR_WIDTH = 6;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   n_busy;

    ram_ws_rs_tag_multiway_if #(
        .NB_WAYS    (NB_WAYS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus_if ();

    ram_ws_rs_tag_multiway #(
        .NB_WAYS    (NB_WAYS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [6:0] wdata, input logic [3:0] way_en);
        bus_if.req_i    = 1'b1;
        bus_if.write_i  = 1'b1;
        bus_if.addr_i   = addr;
        bus_if.wdata_i  = wdata;
        bus_if.way_en_i = way_en;
        step();
        bus_if.req_i    = 1'b0;
        bus_if.write_i  = 1'b0;
        bus_if.way_en_i = '0;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [5:0] tag);
        bus_if.req_i     = 1'b1;
        bus_if.write_i   = 1'b0;
        bus_if.addr_i    = addr;
        bus_if.cmp_tag_i = tag;
        step();
        bus_if.req_i     = 1'b0;
    endtask

    // Counts consecutive busy cycles; pulses flush_req_i at busy cycle pulse_at.
    task automatic wait_flush(output int n, input int pulse_at);
        n = 0;
        while (bus_if.flush_busy_o === 1'b1 && n < 200) begin
            bus_if.flush_req_i = (n == pulse_at);
            n++;
            step();
        end
        bus_if.flush_req_i = 1'b0;
    endtask

    initial begin
        logic [27:0] exp_rd;
        n_assert = 0;
        n_fail   = 0;
        rst                = 1'b1;
        bus_if.req_i       = 1'b0;
        bus_if.write_i     = 1'b0;
        bus_if.way_en_i    = '0;
        bus_if.addr_i      = '0;
        bus_if.wdata_i     = '0;
        bus_if.cmp_tag_i   = '0;
        bus_if.flush_req_i = 1'b0;

        // Power-on reset, two cycles
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rvalid", 64'(bus_if.rvalid_o), 64'd0);
        check("rst_hit", 64'(bus_if.hit_o), 64'd0);
        check("rst_hit_way", 64'(bus_if.hit_way_o), 64'd0);
        check("rst_perr", 64'(bus_if.parity_err_o), 64'd0);
        check("rst_rdata", 64'(bus_if.rdata_o), 64'd0);
        check("rst_gnt", 64'(bus_if.gnt_o), 64'd0);
        wait_flush(n_busy, -1);
        check("rst_flush_len", 64'(n_busy), 64'd64);
        check("idle_gnt", 64'(bus_if.gnt_o), 64'd1);

        do_read(6'd5, 6'd0);
        check("rd5_rvalid", 64'(bus_if.rvalid_o), 64'd1);
        check("rd5_rdata", 64'(bus_if.rdata_o), 64'd0);
        check("rd5_hit", 64'(bus_if.hit_o), 64'd0);

        // Write way 2 of set 3, read back with matching tag
        do_write(6'd3, 7'h55, 4'b0100);
        check("wr_rvalid", 64'(bus_if.rvalid_o), 64'd0);
        do_read(6'd3, 6'h15);
        exp_rd = 28'h0154000;
        check("rd3_rvalid", 64'(bus_if.rvalid_o), 64'd1);
        check("rd3_hit", 64'(bus_if.hit_o), 64'd1);
        check("rd3_hit_way", 64'(bus_if.hit_way_o), 64'b0100);
        check("rd3_rdata", 64'(bus_if.rdata_o), 64'(exp_rd));

        // Idle cycle: data held, no valid, no hit
        step();
        check("idle_rvalid", 64'(bus_if.rvalid_o), 64'd0);
        check("idle_hit", 64'(bus_if.hit_o), 64'd0);
        check("idle_hit_way", 64'(bus_if.hit_way_o), 64'd0);
        check("idle_rdata_hold", 64'(bus_if.rdata_o), 64'(exp_rd));

        // Invalid entry with matching tag in way 0 must not hit
        do_write(6'd3, 7'h15, 4'b0001);
        do_read(6'd3, 6'h15);
        check("inv_hit_way", 64'(bus_if.hit_way_o), 64'b0100);
        check("inv_rdata", 64'(bus_if.rdata_o), 64'h0154015);

        // Empty write mask is a no-op
        do_write(6'd3, 7'h7f, 4'b0000);
        do_read(6'd3, 6'h15);
        check("noop_rdata", 64'(bus_if.rdata_o), 64'h0154015);

        // Tag miss
        do_read(6'd3, 6'h16);
        check("miss_hit", 64'(bus_if.hit_o), 64'd0);

        // Multiple hits reported as-is
        do_write(6'd3, 7'h55, 4'b0010);
        do_read(6'd3, 6'h15);
        check("multi_hit_way", 64'(bus_if.hit_way_o), 64'b0110);
        check("multi_hit", 64'(bus_if.hit_o), 64'd1);

        // Top set index, no wrap-around into set 0
        do_write(6'd63, 7'h6a, 4'b1000);
        do_read(6'd63, 6'h2a);
        check("top_hit_way", 64'(bus_if.hit_way_o), 64'b1000);
        do_read(6'd0, 6'h2a);
        check("set0_rdata", 64'(bus_if.rdata_o), 64'd0);

        // Flush collides with a read request
        bus_if.flush_req_i = 1'b1;
        bus_if.req_i       = 1'b1;
        bus_if.write_i     = 1'b0;
        bus_if.addr_i      = 6'd3;
        bus_if.cmp_tag_i   = 6'h15;
        #1;
        check("coll_gnt", 64'(bus_if.gnt_o), 64'd0);
        @(posedge clk);
        #1;
        bus_if.flush_req_i = 1'b0;
        bus_if.req_i       = 1'b0;
        check("coll_rvalid", 64'(bus_if.rvalid_o), 64'd0);
        check("coll_busy", 64'(bus_if.flush_busy_o), 64'd1);
        wait_flush(n_busy, 10);
        check("coll_flush_len", 64'(n_busy), 64'd64);
        for (int s = 0; s < 64; s++) begin
            do_read(6'(s), 6'h15);
            check("flushed_rdata", 64'(bus_if.rdata_o), 64'd0);
            check("flushed_hit", 64'(bus_if.hit_o), 64'd0);
        end

        // Reset at flush cycle 30 restarts the sweep
        bus_if.flush_req_i = 1'b1;
        step();
        bus_if.flush_req_i = 1'b0;
        repeat (30) step();
        check("mid_busy", 64'(bus_if.flush_busy_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_flush(n_busy, -1);
        check("mid_rst_flush_len", 64'(n_busy), 64'd64);

        // Corrupted stored bit in way 1 of set 7
        do_write(6'd7, 7'h55, 4'b1111);
`ifdef TAG_PARITY_EN
        dut.r_mem[7][1] = dut.r_mem[7][1] ^ 8'h01;
`endif
        do_read(6'd7, 6'h15);
`ifdef TAG_PARITY_EN
        check("par_perr", 64'(bus_if.parity_err_o), 64'b0010);
        check("par_hit_way", 64'(bus_if.hit_way_o), 64'b1101);
`else
        check("par_perr", 64'(bus_if.parity_err_o), 64'b0000);
        check("par_hit_way", 64'(bus_if.hit_way_o), 64'b1111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
